// File: rtl/hdlc_bus_ctrl.sv
// hdlc_bus_ctrl: single-master sequencer for the Hdlc 8-bit register port, streaming host TX frames in and RX frames out
// Ports: Clk/Rst (async, active-high); Address/WriteEnable/ReadEnable/DataIn/DataOut = Hdlc register port;
// Rx_Ready/Tx_Done = Hdlc status pins; tx_* = host TX byte stream in; rx_* = host RX byte stream out;
// tx_trunc pulses when a frame is cut at MAX_TX_LEN, rx_drop pulses when a received frame is discarded.
module hdlc_bus_ctrl #(
  parameter int unsigned MAX_TX_LEN = 126,
  parameter bit          FCS_EN     = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  output logic [2:0] Address,
  output logic       WriteEnable,
  output logic       ReadEnable,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut,
  input  logic       Rx_Ready,
  input  logic       Tx_Done,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_trunc,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_last,
  output logic       rx_err,
  input  logic       rx_ready,
  output logic       rx_drop
);
  localparam logic [7:0] SC_INIT = FCS_EN ? 8'h20 : 8'h00;
  localparam logic [7:0] SC_DROP = SC_INIT | 8'h02;
  localparam logic [6:0] CNT_MAX = 7'(MAX_TX_LEN - 1);
  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_TX_WR, S_TX_GO, S_TX_SKIP,
    S_RX_STAT, S_RX_LEN, S_RX_CHK, S_RX_RD, S_RX_OUT, S_RX_DROP
  } state_t;
  state_t     r_state, w_next;
  logic [6:0] r_cnt;
  logic       r_skip;
  logic       r_inflight;
  logic       r_armed;
  logic       r_last_tx;
  logic       r_bad;
  logic       r_ovf;
  logic [7:0] r_rem;
  logic       r_fresh;
  logic [7:0] r_hold;
  logic       w_tx_req, w_rx_req, w_grant_rx, w_at_max, w_rx_end;
  logic [7:0] w_rx_byte;
  assign w_tx_req   = tx_valid & ~r_inflight;
  assign w_rx_req   = Rx_Ready & r_armed;
  assign w_grant_rx = w_rx_req & (~w_tx_req | r_last_tx);
  assign w_at_max   = r_cnt == CNT_MAX;
  // Read data is only valid in the cycle after the read; later stall cycles replay the held copy.
  assign w_rx_byte  = r_fresh ? DataOut : r_hold;
  assign w_rx_end   = (r_state == S_RX_OUT && rx_ready && r_rem == 8'd0) || r_state == S_RX_DROP;
  assign rx_data    = rx_valid ? w_rx_byte : 8'h00;
  assign rx_last    = rx_valid & (r_rem == 8'd0);
  assign rx_err     = rx_last & r_ovf;
  always_comb begin
    w_next      = r_state;
    Address     = 3'd0;
    WriteEnable = 1'b0;
    ReadEnable  = 1'b0;
    DataIn      = 8'h00;
    tx_ready    = 1'b0;
    tx_trunc    = 1'b0;
    rx_valid    = 1'b0;
    rx_drop     = 1'b0;
    case (r_state)
      S_INIT: begin
        // Keep the port quiet while reset is still held.
        if (!Rst) begin
          Address     = 3'd2;
          WriteEnable = 1'b1;
          DataIn      = SC_INIT;
        end
        w_next = S_IDLE;
      end
      S_IDLE: w_next = w_grant_rx ? S_RX_STAT : w_tx_req ? S_TX_WR : S_IDLE;
      S_TX_WR: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          Address     = 3'd1;
          WriteEnable = 1'b1;
          DataIn      = tx_data;
          tx_trunc    = w_at_max & ~tx_last;
          if (tx_last || w_at_max) w_next = S_TX_GO;
        end
      end
      S_TX_GO: begin
        WriteEnable = 1'b1;
        DataIn      = 8'h02;
        w_next      = r_skip ? S_TX_SKIP : S_IDLE;
      end
      S_TX_SKIP: begin
        tx_ready = 1'b1;
        if (tx_valid && tx_last) w_next = S_IDLE;
      end
      S_RX_STAT: begin
        Address    = 3'd2;
        ReadEnable = 1'b1;
        w_next     = S_RX_LEN;
      end
      S_RX_LEN: begin
        Address    = 3'd4;
        ReadEnable = 1'b1;
        w_next     = S_RX_CHK;
      end
      S_RX_CHK: w_next = (r_bad || DataOut == 8'd0) ? S_RX_DROP : S_RX_RD;
      S_RX_RD: begin
        Address    = 3'd3;
        ReadEnable = 1'b1;
        w_next     = S_RX_OUT;
      end
      S_RX_OUT: begin
        rx_valid = 1'b1;
        if (rx_ready) w_next = r_rem != 8'd0 ? S_RX_RD : S_IDLE;
      end
      S_RX_DROP: begin
        Address     = 3'd2;
        WriteEnable = 1'b1;
        DataIn      = SC_DROP;
        rx_drop     = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_INIT;
    endcase
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= S_INIT;
      r_cnt      <= 7'd0;
      r_skip     <= 1'b0;
      r_inflight <= 1'b0;
      r_armed    <= 1'b1;
      r_last_tx  <= 1'b1;
      r_bad      <= 1'b0;
      r_ovf      <= 1'b0;
      r_rem      <= 8'd0;
      r_fresh    <= 1'b0;
      r_hold     <= 8'h00;
    end else begin
      r_state    <= w_next;
      r_fresh    <= r_state == S_RX_RD;
      r_cnt      <= r_state == S_TX_WR ? r_cnt + 7'(tx_valid) : 7'd0;
      r_inflight <= r_state == S_TX_GO || (r_inflight && !(Tx_Done && r_state != S_TX_WR));
      // A low sample re-arms even on the job's last cycle, so a fresh frame is never missed.
      r_armed    <= ~Rx_Ready | (r_armed & ~w_rx_end);
      if (r_state == S_RX_OUT) r_hold <= w_rx_byte;
      if (r_state == S_IDLE && (w_tx_req || w_rx_req)) r_last_tx <= ~w_grant_rx;
      if (tx_trunc) r_skip <= 1'b1;
      else if (r_state == S_TX_GO) r_skip <= 1'b0;
      if (r_state == S_RX_LEN) begin
        r_bad <= DataOut[2] | DataOut[3];
        r_ovf <= DataOut[4];
      end
      if (r_state == S_RX_CHK) r_rem <= DataOut;
      else if (r_state == S_RX_RD && r_rem != 8'd0) r_rem <= r_rem - 8'd1;
    end
  end
endmodule

// File: tb/tb_hdlc_bus_ctrl.sv
// tb_hdlc_bus_ctrl: directed bench for hdlc_bus_ctrl with a small Hdlc register-port responder and access log
module tb_hdlc_bus_ctrl;
  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [2:0] Address;
  logic       WriteEnable, ReadEnable;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       Rx_Ready = 1'b0, Tx_Done = 1'b0;
  logic       tx_valid = 1'b0, tx_last = 1'b0, rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_trunc, rx_valid, rx_last, rx_err, rx_drop;
  logic [7:0] rx_data;
  logic [7:0] m_rxsc = 8'h20, m_rxlen = 8'h00;
  int n_vec = 0, n_err = 0, cyc = 0, ptr = 0, n_trunc = 0;
  typedef struct {int c; logic w; logic [2:0] a; logic [7:0] d;} acc_t;
  acc_t log_q[$];

  hdlc_bus_ctrl #(.MAX_TX_LEN(126), .FCS_EN(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .Address(Address), .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
    .DataIn(DataIn), .DataOut(DataOut), .Rx_Ready(Rx_Ready), .Tx_Done(Tx_Done),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready), .tx_trunc(tx_trunc),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_err(rx_err), .rx_ready(rx_ready),
    .rx_drop(rx_drop)
  );

  always #5 Clk = ~Clk;

  // Hdlc register-port responder: read data appears the cycle after ReadEnable; Rx_Buff yields 50,51,...
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Rst) begin
      ptr     <= 0;
      DataOut <= 8'h00;
    end else begin
      if (WriteEnable || ReadEnable) log_q.push_back(acc_t'{cyc, WriteEnable, Address, DataIn});
      if (tx_trunc) n_trunc <= n_trunc + 1;
      if (ReadEnable) begin
        DataOut <= Address == 3'd2 ? m_rxsc : Address == 3'd4 ? m_rxlen :
                   Address == 3'd3 ? 8'h50 + 8'(ptr) : 8'h00;
        if (Address == 3'd3) ptr <= ptr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic acc(input string tag, input int idx, input logic w, input logic [2:0] a,
                     input logic [7:0] d, input int c0, input int dc);
    acc_t e = '{-1, 1'b0, 3'd7, 8'hee};
    if (idx < log_q.size()) e = log_q[idx];
    chk({tag, "_acc"}, 32'({e.w, e.a, e.d}), 32'({w, a, d}));
    chk({tag, "_cyc"}, e.c - c0, dc);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int k = 0;
    tx_valid = 1'b1; tx_data = d; tx_last = l;
    #1;
    while (!tx_ready && k < 50) begin
      @(negedge Clk); #1; k++;
    end
    chk("tx_ready_wait", 32'(k < 50), 1);
    @(negedge Clk);
  endtask

  initial begin
    int base, s, nv, nd, first_v, tr0, k;
    // Reset state
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_bus", 32'({Address, WriteEnable, ReadEnable, DataIn}), 0);
    chk("rst_host", 32'({tx_ready, tx_trunc, rx_valid, rx_data, rx_last, rx_err, rx_drop}), 0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("init_write", 32'({Address, WriteEnable, ReadEnable, DataIn}), 32'({3'd2, 1'b1, 1'b0, 8'h20}));
    repeat (6) @(negedge Clk);
    #1;
    chk("idle_quiet", log_q.size(), 1);
    // TX frame A1,B2,C3 with Tx_Done low
    base = log_q.size();
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b1);
    tx_valid = 1'b0; tx_last = 1'b0;
    #1;
    chk("tx_go_cycle", 32'({tx_ready, WriteEnable, Address, DataIn}), 32'({1'b0, 1'b1, 3'd0, 8'h02}));
    @(negedge Clk);
    s = log_q[base].c;
    acc("tx3_b0", base, 1'b1, 3'd1, 8'hA1, s, 0);
    acc("tx3_b1", base + 1, 1'b1, 3'd1, 8'hB2, s, 1);
    acc("tx3_b2", base + 2, 1'b1, 3'd1, 8'hC3, s, 2);
    acc("tx3_go", base + 3, 1'b1, 3'd0, 8'h02, s, 3);
    // Next frame blocked while the previous one is in flight
    tx_valid = 1'b1; tx_data = 8'hD4; tx_last = 1'b1;
    repeat (5) @(negedge Clk);
    #1;
    chk("tx_blocked_ready", 32'(tx_ready), 0);
    chk("tx_blocked_bus", log_q.size(), base + 4);
    Tx_Done = 1'b1;
    send(8'hD4, 1'b1);
    Tx_Done = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;
    @(negedge Clk);
    #1;
    s = log_q[log_q.size() - 2].c;
    acc("tx_d4", log_q.size() - 2, 1'b1, 3'd1, 8'hD4, s, 0);
    acc("tx_d4_go", log_q.size() - 1, 1'b1, 3'd0, 8'h02, s, 1);
    // RX frame, Rx_SC=20, len 4, host always ready
    m_rxsc = 8'h20; m_rxlen = 8'd4; rx_ready = 1'b1;
    base = log_q.size(); nv = 0; first_v = -1;
    Rx_Ready = 1'b1;
    for (k = 0; k < 40; k++) begin
      @(negedge Clk); #1;
      if (rx_valid) begin
        if (first_v < 0) first_v = cyc;
        chk($sformatf("rx4_data%0d", nv), 32'(rx_data), 32'(8'h50 + 8'(nv)));
        chk($sformatf("rx4_last%0d", nv), 32'(rx_last), 32'(nv == 3));
        chk($sformatf("rx4_err%0d", nv), 32'(rx_err), 0);
        nv++;
        if (rx_last) break;
      end
    end
    chk("rx4_count", nv, 4);
    repeat (6) @(negedge Clk);
    #1;
    s = log_q[base].c;
    chk("rx4_first_valid", first_v - s, 4);
    chk("rx4_no_reserve", log_q.size(), base + 6);
    acc("rx4_stat", base, 1'b0, 3'd2, 8'h00, s, 0);
    acc("rx4_len", base + 1, 1'b0, 3'd4, 8'h00, s, 1);
    acc("rx4_rd0", base + 2, 1'b0, 3'd3, 8'h00, s, 3);
    acc("rx4_rd3", base + 5, 1'b0, 3'd3, 8'h00, s, 9);
    Rx_Ready = 1'b0;
    repeat (2) @(negedge Clk);
    // RX frame with FrameError is dropped
    m_rxsc = 8'h24; m_rxlen = 8'd3;
    base = log_q.size(); nv = 0; nd = 0;
    Rx_Ready = 1'b1;
    for (k = 0; k < 12; k++) begin
      @(negedge Clk); #1;
      if (rx_drop) begin nd++; Rx_Ready = 1'b0; end
      if (rx_valid) nv++;
    end
    chk("drop_pulses", nd, 1);
    chk("drop_no_valid", nv, 0);
    chk("drop_bus_count", log_q.size(), base + 3);
    s = log_q[base].c;
    acc("drop_stat", base, 1'b0, 3'd2, 8'h00, s, 0);
    acc("drop_len", base + 1, 1'b0, 3'd4, 8'h00, s, 1);
    acc("drop_wr", base + 2, 1'b1, 3'd2, 8'h22, s, 3);
    // 130-byte TX frame cut at 126
    Tx_Done = 1'b1;
    repeat (2) @(negedge Clk);
    Tx_Done = 1'b0;
    base = log_q.size(); tr0 = n_trunc;
    for (int i = 0; i < 130; i++) send(8'(i), 1'(i == 129));
    tx_valid = 1'b0; tx_last = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    chk("trunc_bus_count", log_q.size(), base + 127);
    s = log_q[base].c;
    for (int i = 0; i < 126; i++) acc($sformatf("trunc_w%0d", i), base + i, 1'b1, 3'd1, 8'(i), s, i);
    acc("trunc_go", base + 126, 1'b1, 3'd0, 8'h02, s, 126);
    chk("trunc_pulses", n_trunc - tr0, 1);
    // Reset, then TX and RX pending together twice
    Rst = 1'b1;
    @(negedge Clk);
    m_rxsc = 8'h20; m_rxlen = 8'd2; rx_ready = 1'b0;
    Rx_Ready = 1'b1; tx_valid = 1'b1; tx_data = 8'hE5; tx_last = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    base = log_q.size();
    for (k = 0; k < 20; k++) begin
      @(negedge Clk); #1;
      if (rx_valid) break;
    end
    chk("arb_rx_first_valid", 32'(rx_valid), 1);
    chk("arb_rx_first_data", 32'(rx_data), 32'h50);
    chk("arb_tx_waits", 32'(tx_ready), 0);
    repeat (2) begin
      @(negedge Clk); #1;
      chk("stall_hold", 32'({rx_valid, rx_data}), 32'({1'b1, 8'h50}));
    end
    rx_ready = 1'b1;
    for (k = 0; k < 10; k++) begin
      @(negedge Clk); #1;
      if (rx_valid && rx_last) break;
    end
    chk("arb_rx_last", 32'({rx_valid, rx_last, rx_data}), 32'({1'b1, 1'b1, 8'h51}));
    Rx_Ready = 1'b0;
    @(negedge Clk);
    Rx_Ready = 1'b1;
    @(negedge Clk); #1;
    chk("arb_tx_second", 32'({tx_ready, WriteEnable, Address, DataIn}), 32'({1'b1, 1'b1, 3'd1, 8'hE5}));
    @(negedge Clk);
    tx_valid = 1'b0; tx_last = 1'b0;
    s = log_q[base].c;
    acc("arb_init", base, 1'b1, 3'd2, 8'h20, s, 0);
    acc("arb_g1_rx", base + 1, 1'b0, 3'd2, 8'h00, s, 2);
    acc("arb_g2_tx", base + 5, 1'b1, 3'd1, 8'hE5, log_q[base + 5].c, 0);
    for (k = 0; k < 20; k++) begin
      @(negedge Clk); #1;
      if (rx_valid) break;
    end
    chk("arb_rx_again", 32'({rx_valid, rx_data}), 32'({1'b1, 8'h52}));
    // Reset in the middle of RX_OUT
    Rst = 1'b1;
    #1;
    chk("midjob_rst_bus", 32'({Address, WriteEnable, ReadEnable, DataIn}), 0);
    chk("midjob_rst_host", 32'({tx_ready, tx_trunc, rx_valid, rx_data, rx_last, rx_err, rx_drop}), 0);
    @(negedge Clk);
    Rst = 1'b0; Rx_Ready = 1'b0; rx_ready = 1'b0;
    #1;
    chk("reinit_write", 32'({Address, WriteEnable, ReadEnable, DataIn}), 32'({3'd2, 1'b1, 1'b0, 8'h20}));
    @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
